// File: rtl/scs8hd_mux_pkg.sv
// rtl/scs8hd_mux_pkg.sv - shared types and helpers for the registered N:1 mux
// FSM states, guard counter width and select range check.
package scs8hd_mux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SWITCH = 1'b1
  } state_e;

  localparam int CNT_W = 4;

  function automatic logic sel_in_range(input logic [31:0] s, input logic [31:0] nch);
    return (s < nch);
  endfunction

endpackage

// File: rtl/scs8hd_muxn_comb.sv
// rtl/scs8hd_muxn_comb.sv - combinational NCH:1 WIDTH-bit selector
// Binary tree of 2:1 muxes in heap order; leaves beyond NCH are tied to zero.
module scs8hd_muxn_comb #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH*WIDTH-1:0] A,
  input  logic [SW-1:0]        S,
  output logic [WIDTH-1:0]     X
);

  localparam int L = 1 << SW;

  logic [WIDTH-1:0] t [2*L-1];

  for (genvar k = 0; k < L; k++) begin : g_leaf
    if (k < NCH) begin : g_used
      assign t[L-1+k] = A[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign t[L-1+k] = '0;
    end
  end

  // Node i sits at depth clog2(i+2)-1; the root decodes the select MSB.
  for (genvar i = 0; i < L-1; i++) begin : g_node
    localparam int D = $clog2(i+2) - 1;
    scs8hd_pg_U_MUX_2_1 #(.WIDTH(WIDTH)) u_mux (
      .A0(t[2*i+1]),
      .A1(t[2*i+2]),
      .S (S[SW-1-D]),
      .X (t[i])
    );
  end

  assign X = t[0];

endmodule

// File: rtl/scs8hd_pg_U_MUX_2_1.sv
// rtl/scs8hd_pg_U_MUX_2_1.sv - WIDTH-bit 2:1 mux leaf used to build selector trees
module scs8hd_pg_U_MUX_2_1 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] A1,
  input  logic             S,
  output logic [WIDTH-1:0] X
);

  assign X = S ? A1 : A0;

endmodule

// File: rtl/scs8hd_muxn_reg.sv
// rtl/scs8hd_muxn_reg.sv - registered NCH:1 mux with handshaked, guarded select
// Select changes pass through SWITCH so X never mixes old and new channels.
module scs8hd_muxn_reg
  import scs8hd_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SW    = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int GUARD = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NCH*WIDTH-1:0] A,
  input  logic [SW-1:0]        S,
  input  logic                 S_VALID,
  output logic                 S_READY,
  input  logic                 DE,
  output logic [WIDTH-1:0]     X,
  output logic [SW-1:0]        SEL_Q,
  output logic                 BUSY,
  output logic                 ERR
`ifdef SC_USE_PG_PIN
  ,
  input  logic                 vpwr,
  input  logic                 vgnd,
  input  logic                 vpb,
  input  logic                 vnb
`endif
);

`ifndef SC_USE_PG_PIN
  supply1 vpwr;
  supply0 vgnd;
  supply1 vpb;
  supply0 vnb;
`endif

  logic pg_unused;
  assign pg_unused = ^{vpwr, vgnd, vpb, vnb};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    pend_q, pend_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] ch_data;
  logic             accept;
  logic             in_range;

  scs8hd_muxn_comb #(.WIDTH(WIDTH), .NCH(NCH), .SW(SW)) u_comb (
    .A(A),
    .S(sel_q),
    .X(ch_data)
  );

  assign S_READY  = (state_q == IDLE) && !RESET;
  assign BUSY     = (state_q == SWITCH);
  assign accept   = S_VALID && S_READY;
  assign in_range = sel_in_range(32'(S), 32'(NCH));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      sel_q   <= '0;
      x_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
      x_q     <= x_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    sel_d   = sel_q;
    x_d     = x_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && !in_range) begin
          err_d = 1'b1;
          if (DE) x_d = ch_data;
        end else if (accept && (S != sel_q)) begin
          // X freezes on the accepting edge; the old channel is not sampled again.
          state_d = SWITCH;
          pend_d  = S;
          cnt_d   = CNT_W'(GUARD);
        end else if (DE) begin
          x_d = ch_data;
        end
      end
      SWITCH: begin
        if (cnt_q == '0) begin
          sel_d   = pend_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  assign X     = x_q;
  assign SEL_Q = sel_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_scs8hd_muxn_reg.sv
// tb/tb_scs8hd_muxn_reg.sv - directed bench for scs8hd_muxn_reg
module tb_scs8hd_muxn_reg;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        DE;
  logic [31:0] A;
  logic [1:0]  S;
  logic        v4, v3, v0;

  logic       r4, r3, r0;
  logic       b4, b3, b0;
  logic       e4, e3, e0;
  logic [7:0] x4, x3, x0;
  logic [1:0] q4, q3, q0;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  scs8hd_muxn_reg #(.WIDTH(8), .NCH(4), .GUARD(2)) u4 (
    .CLK(CLK), .RESET(RESET), .A(A), .S(S), .S_VALID(v4), .S_READY(r4),
    .DE(DE), .X(x4), .SEL_Q(q4), .BUSY(b4), .ERR(e4)
  );

  scs8hd_muxn_reg #(.WIDTH(8), .NCH(3), .GUARD(2)) u3 (
    .CLK(CLK), .RESET(RESET), .A(A[23:0]), .S(S), .S_VALID(v3), .S_READY(r3),
    .DE(DE), .X(x3), .SEL_Q(q3), .BUSY(b3), .ERR(e3)
  );

  scs8hd_muxn_reg #(.WIDTH(8), .NCH(4), .GUARD(0)) u0 (
    .CLK(CLK), .RESET(RESET), .A(A), .S(S), .S_VALID(v0), .S_READY(r0),
    .DE(DE), .X(x0), .SEL_Q(q0), .BUSY(b0), .ERR(e0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [7:0] v);
    A[k*8 +: 8] = v;
  endtask

  initial begin
    RESET = 1'b1;
    DE    = 1'b1;
    A     = $urandom;
    S     = 2'd0;
    v4 = 1'b0; v3 = 1'b0; v0 = 1'b0;

    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_x", 32'(x4), 32'h0);
      chk("rst_sel", 32'(q4), 32'h0);
      chk("rst_busy", 32'(b4), 32'h0);
      chk("rst_err", 32'(e4), 32'h0);
      chk("rst_ready", 32'(r4), 32'h0);
      A = $urandom;
    end

    RESET = 1'b0;
    set_ch(0, 8'h11);
    #1;
    chk("post_rst_ready", 32'(r4), 32'h1);
    tick();
    chk("steady_11", 32'(x4), 32'h11);
    set_ch(0, 8'h22);
    tick();
    chk("steady_22", 32'(x4), 32'h22);
    set_ch(0, 8'h33);
    DE = 1'b0;
    tick();
    chk("de_hold1", 32'(x4), 32'h22);
    tick();
    chk("de_hold2", 32'(x4), 32'h22);
    DE = 1'b1;
    tick();
    chk("steady_33", 32'(x4), 32'h33);

    set_ch(2, 8'hA5);
    set_ch(0, 8'h44);
    S  = 2'd2;
    v4 = 1'b1;
    tick();
    v4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("sw_busy", 32'(b4), 32'h1);
      chk("sw_ready", 32'(r4), 32'h0);
      chk("sw_xfrozen", 32'(x4), 32'h33);
      chk("sw_sel_old", 32'(q4), 32'h0);
      tick();
    end
    chk("sw_done_busy", 32'(b4), 32'h0);
    chk("sw_done_sel", 32'(q4), 32'h2);
    chk("sw_done_x", 32'(x4), 32'h33);
    tick();
    chk("sw_new_x", 32'(x4), 32'hA5);

    set_ch(0, 8'h5A);
    S  = 2'd3;
    v3 = 1'b1;
    tick();
    v3 = 1'b0;
    chk("oor_err", 32'(e3), 32'h1);
    chk("oor_busy", 32'(b3), 32'h0);
    chk("oor_sel", 32'(q3), 32'h0);
    chk("oor_x", 32'(x3), 32'h5A);
    tick();
    chk("oor_err_clear", 32'(e3), 32'h0);
    S  = 2'd0;
    v3 = 1'b1;
    tick();
    v3 = 1'b0;
    chk("same_busy", 32'(b3), 32'h0);
    chk("same_err", 32'(e3), 32'h0);
    chk("same_sel", 32'(q3), 32'h0);

    set_ch(1, 8'h77);
    S  = 2'd1;
    v4 = 1'b1;
    tick();
    v4 = 1'b0;
    chk("mid_busy1", 32'(b4), 32'h1);
    tick();
    chk("mid_busy2", 32'(b4), 32'h1);
    RESET = 1'b1;
    tick();
    chk("mid_rst_sel", 32'(q4), 32'h0);
    chk("mid_rst_x", 32'(x4), 32'h0);
    chk("mid_rst_busy", 32'(b4), 32'h0);
    RESET = 1'b0;
    set_ch(0, 8'h3C);
    tick();
    chk("mid_post_x", 32'(x4), 32'h3C);
    chk("mid_post_sel", 32'(q4), 32'h0);
    tick();
    chk("mid_discard_sel", 32'(q4), 32'h0);
    chk("mid_discard_busy", 32'(b4), 32'h0);

    set_ch(3, 8'h5C);
    S  = 2'd1;
    v0 = 1'b1;
    #1;
    chk("g0_ready", 32'(r0), 32'h1);
    tick();
    chk("g0_busy", 32'(b0), 32'h1);
    chk("g0_notready", 32'(r0), 32'h0);
    chk("g0_xfrozen", 32'(x0), 32'h3C);
    S = 2'd3;
    tick();
    chk("g0_sel1", 32'(q0), 32'h1);
    chk("g0_idle", 32'(b0), 32'h0);
    chk("g0_ready_again", 32'(r0), 32'h1);
    tick();
    v0 = 1'b0;
    chk("g0_b2b_busy", 32'(b0), 32'h1);
    chk("g0_b2b_sel_hold", 32'(q0), 32'h1);
    tick();
    chk("g0_sel3", 32'(q0), 32'h3);
    chk("g0_b2b_idle", 32'(b0), 32'h0);
    tick();
    chk("g0_x_ch3", 32'(x0), 32'h5C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
